// File: rtl/rgmii_nibble_tx_if.sv
// Byte stream into rgmii_nibble_tx: {s_last,s_data} with a valid/ready handshake.
interface rgmii_nibble_tx_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/rgmii_nibble_tx.sv
// Byte stream -> {last,data} FIFO -> 4-bit tx_en/tx_d serialiser, low nibble first, with IFG.
// Define RGMII_TX_PREAMBLE_EN to prefix every frame with 7x 0x55 + 0xD5.
module rgmii_nibble_tx #(
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter int unsigned IFG_NIBBLES = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    rgmii_nibble_tx_if.slave         src,
    output logic                     tx_en,
    output logic [3:0]               tx_d,
    output logic                     tx_busy,
    output logic                     underrun
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned IW = $clog2(IFG_NIBBLES + 1);

    typedef enum logic [2:0] {
        StIdle,
`ifdef RGMII_TX_PREAMBLE_EN
        StPre,
`endif
        StDataLo,
        StDataHi,
        StIfg
    } state_e;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_next;
    logic [AW:0]   fill;
    logic [AW:0]   frames_q;
    logic          full;
    logic          push;
    logic          push_last;
    logic          pop;
    logic          pop_last;
    logic          last_left;
    logic [8:0]    head;
    logic [8:0]    next_head;
    state_e        state_q;
    logic [IW-1:0] ifg_cnt_q;
`ifdef RGMII_TX_PREAMBLE_EN
    logic [3:0]    pre_cnt_q;
`endif

    always_comb begin
        fill      = wr_ptr_q - rd_ptr_q;
        rd_next   = rd_ptr_q + 1'b1;
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push      = src.s_valid && !full;
        push_last = push && src.s_last;
        pop       = (state_q == StDataHi);
        head      = mem[rd_ptr_q[AW-1:0]];
        pop_last  = pop && head[8];
        last_left = (fill == (AW + 1)'(1));
        // Popping the only stored entry: a same-cycle push becomes the next head.
        next_head = last_left ? {src.s_last, src.s_data} : mem[rd_next[AW-1:0]];
    end

    assign src.s_ready = !full;
    assign tx_busy     = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {src.s_last, src.s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            frames_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_next;
            end
            if (push_last && !pop_last) begin
                frames_q <= frames_q + 1'b1;
            end else if (pop_last && !push_last) begin
                frames_q <= frames_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            tx_en     <= 1'b0;
            tx_d      <= 4'h0;
            underrun  <= 1'b0;
            ifg_cnt_q <= '0;
`ifdef RGMII_TX_PREAMBLE_EN
            pre_cnt_q <= 4'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Starting on full avoids deadlock on frames longer than the FIFO.
                    if (frames_q != '0 || full) begin
                        tx_en <= 1'b1;
`ifdef RGMII_TX_PREAMBLE_EN
                        state_q   <= StPre;
                        pre_cnt_q <= 4'd0;
                        tx_d      <= 4'h5;
`else
                        state_q <= StDataLo;
                        tx_d    <= head[3:0];
`endif
                    end
                end
`ifdef RGMII_TX_PREAMBLE_EN
                StPre: begin
                    if (pre_cnt_q == 4'd15) begin
                        state_q <= StDataLo;
                        tx_d    <= head[3:0];
                    end else begin
                        pre_cnt_q <= pre_cnt_q + 4'd1;
                        tx_d      <= (pre_cnt_q == 4'd14) ? 4'hD : 4'h5;
                    end
                end
`endif
                StDataLo: begin
                    state_q <= StDataHi;
                    tx_d    <= head[7:4];
                end
                StDataHi: begin
                    if (head[8] || (last_left && !push)) begin
                        if (!head[8]) begin
                            underrun <= 1'b1;
                        end
                        state_q   <= StIfg;
                        tx_en     <= 1'b0;
                        tx_d      <= 4'h0;
                        ifg_cnt_q <= '0;
                    end else begin
                        state_q <= StDataLo;
                        tx_d    <= next_head[3:0];
                    end
                end
                StIfg: begin
                    if (ifg_cnt_q == IW'(IFG_NIBBLES - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        ifg_cnt_q <= ifg_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_en   <= 1'b0;
                    tx_d    <= 4'h0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rgmii_nibble_tx.sv
// Self-checking bench for rgmii_nibble_tx: table vectors, hand sequences, random frames.
// Honours RGMII_TX_PREAMBLE_EN when expecting the nibble stream.
module tb_rgmii_nibble_tx;
    localparam int DEPTH = 64;
    localparam int IFG   = 24;
`ifdef RGMII_TX_PREAMBLE_EN
    localparam int NPRE = 16;
`else
    localparam int NPRE = 0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] data;
        logic [3:0] exp_lo;
        logic [3:0] exp_hi;
    } vec_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       tx_en;
    logic [3:0] tx_d;
    logic       tx_busy;
    logic       underrun;

    rgmii_nibble_tx_if bus ();

    rgmii_nibble_tx #(
        .FIFO_DEPTH  (DEPTH),
        .IFG_NIBBLES (IFG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .src      (bus),
        .tx_en    (tx_en),
        .tx_d     (tx_d),
        .tx_busy  (tx_busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    logic [3:0]  got_nib[$];
    int unsigned got_cyc[$];
    logic [3:0]  exp_nib[$];
    int          exp_fs[$];
    int          checks = 0;
    int          errors = 0;
    int          stalls = 0;

    // Monitor: every nibble seen with tx_en high, tagged with its cycle number.
    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            got_nib.push_back(tx_d);
            got_cyc.push_back(cyc);
        end
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        got_nib.delete();
        got_cyc.delete();
        exp_nib.delete();
        exp_fs.delete();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        tick(1);
        reset  = 1'b0;
        stalls = 0;
        clear_logs();
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (bus.s_ready !== 1'b1 && n < 2000) begin
            tick(1);
            n++;
            stalls++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got s_ready=%b expected 1 within 2000 cycles", bus.s_ready);
        end
        tick(1);
        bus.s_valid = 1'b0;
    endtask

    // Expected nibble stream of one frame, derived from its bytes.
    function automatic void add_frame(input bq_t b);
        exp_fs.push_back(exp_nib.size());
        for (int i = 0; i < NPRE; i++) exp_nib.push_back((i == 15) ? 4'hD : 4'h5);
        foreach (b[i]) begin
            exp_nib.push_back(b[i][3:0]);
            exp_nib.push_back(b[i][7:4]);
        end
    endfunction

    // exact_gap < 0 means only the minimum gap IFG+1 is required between frames.
    task automatic check_stream(input string name, input int exact_gap);
        chk({name, "_len"}, got_nib.size(), exp_nib.size());
        if (got_nib.size() == exp_nib.size()) begin
            for (int f = 0; f < exp_fs.size(); f++) begin
                int s;
                int e;
                int bad;
                int gap;
                s   = exp_fs[f];
                e   = (f + 1 < exp_fs.size()) ? exp_fs[f + 1] : exp_nib.size();
                bad = -1;
                for (int i = s; i < e; i++) begin
                    if (bad < 0 && got_nib[i] !== exp_nib[i]) bad = i;
                end
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL %s_frame%0d nibble %0d: got %h expected %h", name, f, bad - s,
                             got_nib[bad], exp_nib[bad]);
                end
                chk({name, "_contig"}, got_cyc[e - 1] - got_cyc[s], e - s - 1);
                if (f > 0) begin
                    gap = int'(got_cyc[s] - got_cyc[s - 1]) - 1;
                    if (exact_gap >= 0) begin
                        chk({name, "_gap"}, gap, exact_gap);
                    end else begin
                        checks++;
                        if (gap < IFG + 1) begin
                            errors++;
                            $display("FAIL %s_gap: got %0d expected >= %0d", name, gap, IFG + 1);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        vec_t        vecs[5];
        bq_t         b;
        logic [7:0]  d;
        int unsigned nfr;
        int unsigned len;

        vecs[0] = '{8'hA5, 4'h5, 4'hA};
        vecs[1] = '{8'h00, 4'h0, 4'h0};
        vecs[2] = '{8'hFF, 4'hF, 4'hF};
        vecs[3] = '{8'h3C, 4'hC, 4'h3};
        vecs[4] = '{8'h77, 4'h7, 4'h7};

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        tick(2);
        do_reset();
        chk("rst_tx_en", 32'(tx_en), 0);
        chk("rst_tx_d", 32'(tx_d), 0);
        chk("rst_tx_busy", 32'(tx_busy), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_s_ready", 32'(bus.s_ready), 1);

        // Single-byte frames: latency, nibble order, IFG length, busy release.
        foreach (vecs[v]) begin
            do_reset();
            push_byte(vecs[v].data, 1'b1);
            chk("t1_idle_before", 32'(tx_en), 0);
            tick(1);
            chk("t1_latency", 32'(tx_en), 1);
            tick(NPRE + 2);
            chk("t1_en_low", 32'(tx_en), 0);
            chk("t1_busy_ifg_start", 32'(tx_busy), 1);
            tick(IFG - 1);
            chk("t1_busy_ifg_end", 32'(tx_busy), 1);
            tick(1);
            chk("t1_busy_done", 32'(tx_busy), 0);
            chk("t1_underrun", 32'(underrun), 0);
            chk("t1_burst_len", got_nib.size(), NPRE + 2);
            if (got_nib.size() == NPRE + 2) begin
                chk("t1_lo", 32'(got_nib[NPRE]), 32'(vecs[v].exp_lo));
                chk("t1_hi", 32'(got_nib[NPRE + 1]), 32'(vecs[v].exp_hi));
            end
            b = '{vecs[v].data};
            add_frame(b);
            check_stream("t1", -1);
        end

        // Back-to-back frames: exactly IFG+1 low cycles between bursts.
        do_reset();
        push_byte(8'h01, 1'b0);
        push_byte(8'h02, 1'b0);
        push_byte(8'h03, 1'b1);
        push_byte(8'hFF, 1'b1);
        b = '{8'h01, 8'h02, 8'h03};
        add_frame(b);
        b = '{8'hFF};
        add_frame(b);
        tick(2 * (NPRE + 8) + 2 * IFG + 20);
        check_stream("t2", IFG + 1);
        chk("t2_underrun", 32'(underrun), 0);

        // Frame longer than the FIFO with no last: start on full, then underrun.
        do_reset();
        b.delete();
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(i * 3 + 1);
            b.push_back(d);
            push_byte(d, 1'b0);
        end
        chk("t3_stalls", stalls, 0);
        chk("t3_ready_full", 32'(bus.s_ready), 0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        bus.s_last  = 1'b1;
        tick(1);
        chk("t3_ready_held", 32'(bus.s_ready), 0);
        chk("t3_started", 32'(tx_en), 1);
        bus.s_valid = 1'b0;
        chk("t3_underrun_early", 32'(underrun), 0);
        add_frame(b);
        tick(NPRE + 2 * DEPTH + 10);
        check_stream("t3", -1);
        chk("t3_underrun", 32'(underrun), 1);
        chk("t3_tx_en_low", 32'(tx_en), 0);
        chk("t3_ready_drained", 32'(bus.s_ready), 1);

        // Reset during the third data nibble of a 10-byte frame.
        do_reset();
        for (int i = 0; i < 10; i++) push_byte(8'(8'h80 + i), (i == 9));
        tick(1);
        chk("t4_started", 32'(tx_en), 1);
        tick(NPRE + 2);
        chk("t4_third_nibble", 32'(tx_d), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t4_tx_en", 32'(tx_en), 0);
        chk("t4_tx_d", 32'(tx_d), 0);
        chk("t4_busy", 32'(tx_busy), 0);
        chk("t4_ready", 32'(bus.s_ready), 1);
        chk("t4_underrun", 32'(underrun), 0);
        clear_logs();
        push_byte(8'h77, 1'b1);
        b = '{8'h77};
        add_frame(b);
        tick(NPRE + 2 + IFG + 5);
        check_stream("t4", -1);

        // 200-byte frame at one byte per two cycles; both pointers wrap.
        do_reset();
        b.delete();
        for (int i = 0; i < 200; i++) begin
            d = 8'($urandom);
            b.push_back(d);
            push_byte(d, (i == 199));
            tick(1);
        end
        add_frame(b);
        tick(NPRE + 2 * DEPTH + 300);
        check_stream("t5", -1);
        chk("t5_underrun", 32'(underrun), 0);

        // Random batches of short frames, never enough to fill the FIFO.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            nfr = $urandom_range(5, 2);
            for (int f = 0; f < int'(nfr); f++) begin
                len = $urandom_range(8, 1);
                b.delete();
                for (int i = 0; i < int'(len); i++) b.push_back(8'($urandom));
                for (int i = 0; i < int'(len); i++) begin
                    push_byte(b[i], (i == int'(len) - 1));
                    tick(int'($urandom_range(2, 0)));
                end
                add_frame(b);
            end
            tick(int'(nfr) * (NPRE + 16 + IFG + 2) + 40);
            check_stream("t6", -1);
            chk("t6_underrun", 32'(underrun), 0);
            chk("t6_stalls", stalls, 0);
            chk("t6_idle", 32'(tx_busy), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
